// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and default widths for the register-file bus master.
// Build option: REG_FILE_CTRL_VERIFY_EN enables write readback checking in reg_file_ctrl.
package reg_file_ctrl_pkg;

  localparam int DATA_W_DEF     = 9;
  localparam int ADDR_W_DEF     = 3;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/reg_file_ctrl_cmd_fifo.sv
// Command FIFO for reg_file_ctrl: DEPTH entries of cmd_t, show-ahead head.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module reg_file_ctrl_cmd_fifo
  import reg_file_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO refuses a push even when the same edge pops.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Bus master for the 8-entry register file: queues commands and sequences WEN/OEN cycles.
// Build option: REG_FILE_CTRL_VERIFY_EN adds a readback after each write and the VERIFY_ERR port.
//
//  state    | meaning
//  IDLE     | pop the next queued command when one is present
//  WRITE    | RF_WEN high for one cycle, write commits at the exit edge
//  RD_ISSUE | RF_OEN high for one cycle, file latches RF_DOUT at the exit edge
//  RD_WAIT  | capture RF_DOUT into the response (or the readback compare)
//  RESP     | hold RSP_VALID until the consumer takes it
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WR,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [ADDR_W-1:0] RSP_ADDR,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RF_WEN,
  output logic              RF_OEN,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0] RF_DIN,
  input  logic [DATA_W-1:0] RF_DOUT,
  output logic              BUSY
`ifdef REG_FILE_CTRL_VERIFY_EN
  ,
  output logic              VERIFY_ERR
`endif
);

  state_t state;
  cmd_t   push_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;

`ifdef REG_FILE_CTRL_VERIFY_EN
  logic   vfy_pend;
`endif

  assign push_cmd.wr   = CMD_WR;
  assign push_cmd.addr = CMD_ADDR;
  assign push_cmd.data = CMD_DATA;

  assign CMD_READY = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign BUSY      = !fifo_empty || (state != IDLE);

  reg_file_ctrl_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (CMD_VALID),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      RF_WEN    <= 1'b0;
      RF_OEN    <= 1'b0;
      RF_ADDR   <= '0;
      RF_DIN    <= '0;
      RSP_VALID <= 1'b0;
      RSP_ADDR  <= '0;
      RSP_DATA  <= '0;
`ifdef REG_FILE_CTRL_VERIFY_EN
      vfy_pend   <= 1'b0;
      VERIFY_ERR <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            RF_ADDR <= head.addr;
            if (head.wr) begin
              RF_WEN <= 1'b1;
              RF_DIN <= head.data;
              state  <= WRITE;
            end else begin
              RF_OEN <= 1'b1;
              state  <= RD_ISSUE;
            end
          end
        end
        WRITE: begin
          RF_WEN <= 1'b0;
`ifdef REG_FILE_CTRL_VERIFY_EN
          // RF_DIN and RF_ADDR are left untouched so the readback can compare against them.
          RF_OEN   <= 1'b1;
          vfy_pend <= 1'b1;
          state    <= RD_ISSUE;
`else
          state  <= IDLE;
`endif
        end
        RD_ISSUE: begin
          RF_OEN <= 1'b0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
`ifdef REG_FILE_CTRL_VERIFY_EN
          if (vfy_pend) begin
            vfy_pend <= 1'b0;
            if (RF_DOUT != RF_DIN) VERIFY_ERR <= 1'b1;
            state <= IDLE;
          end else begin
            RSP_DATA  <= RF_DOUT;
            RSP_ADDR  <= RF_ADDR;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
`else
          RSP_DATA  <= RF_DOUT;
          RSP_ADDR  <= RF_ADDR;
          RSP_VALID <= 1'b1;
          state     <= RESP;
`endif
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a behavioural 8x9 register file on the RF port.
// Define REG_FILE_CTRL_VERIFY_EN to also exercise the readback-check build.
module tb_reg_file_ctrl;

  logic       CLK;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_WR;
  logic [2:0] CMD_ADDR;
  logic [8:0] CMD_DATA;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [2:0] RSP_ADDR;
  logic [8:0] RSP_DATA;
  logic       RF_WEN;
  logic       RF_OEN;
  logic [2:0] RF_ADDR;
  logic [8:0] RF_DIN;
  logic [8:0] RF_DOUT;
  logic       BUSY;
`ifdef REG_FILE_CTRL_VERIFY_EN
  logic       VERIFY_ERR;
  localparam longint WR_GAP = 40;
`else
  localparam longint WR_GAP = 20;
`endif

  reg_file_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WR    (CMD_WR),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_DATA  (CMD_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ADDR  (RSP_ADDR),
    .RSP_DATA  (RSP_DATA),
    .RF_WEN    (RF_WEN),
    .RF_OEN    (RF_OEN),
    .RF_ADDR   (RF_ADDR),
    .RF_DIN    (RF_DIN),
    .RF_DOUT   (RF_DOUT),
    .BUSY      (BUSY)
`ifdef REG_FILE_CTRL_VERIFY_EN
    ,
    .VERIFY_ERR(VERIFY_ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model plus port monitors.
  typedef struct {
    logic [2:0] a;
    logic [8:0] d;
    longint     t;
  } wr_t;

  logic [8:0] rf_mem [8];
  logic [8:0] rf_q;
  bit         corrupt_a2;
  int         both_cnt;
  int         rsp_cyc;
  wr_t        wlog[$];
  logic [11:0] rlog[$];

  assign RF_DOUT = rf_q;

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    rf_q       = '0;
    corrupt_a2 = 1'b0;
    both_cnt   = 0;
    rsp_cyc    = 0;
  end

  always @(posedge CLK) begin
    if (RF_WEN) begin
      rf_mem[RF_ADDR] <= RF_DIN;
      wlog.push_back('{a: RF_ADDR, d: RF_DIN, t: $time});
    end
    if (RF_OEN) rf_q <= rf_mem[RF_ADDR] ^ ((corrupt_a2 && RF_ADDR == 3'd2) ? 9'h001 : 9'h000);
    if (RF_WEN && RF_OEN) both_cnt++;
    if (RSP_VALID) rsp_cyc++;
    if (RSP_VALID && RSP_READY) rlog.push_back({RSP_ADDR, RSP_DATA});
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Returns #1 after the edge that accepted the command.
  task automatic send(input logic wr, input logic [2:0] addr, input logic [8:0] data);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    CMD_VALID = 1'b1;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_DATA  = data;
    while (!ok && n < 50) begin
      if (CMD_READY === 1'b1) ok = 1'b1;
      tick();
      n++;
    end
    CMD_VALID = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (RSP_VALID !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(RSP_VALID), 32'd1);
  endtask

  logic [8:0] d5 [8];
  int         wbase;
  int         rsp0;

  initial begin
    d5 = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h166, 9'h077, 9'h188};
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_WR    = 1'b0;
    CMD_ADDR  = '0;
    CMD_DATA  = '0;
    RSP_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wen", 32'(RF_WEN), 0);
    chk("rst_oen", 32'(RF_OEN), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
`ifdef REG_FILE_CTRL_VERIFY_EN
    chk("rst_verify_err", 32'(VERIFY_ERR), 0);
`endif
    RST = 1'b0;
    tick();

    // 1: write 05A to addr 3, then read it back
    send(1'b1, 3'd3, 9'h05A);
    chk("t1_wen_e0", 32'(RF_WEN), 0);
    tick();
    chk("t1_wen_e1", 32'(RF_WEN), 1);
    chk("t1_waddr", 32'(RF_ADDR), 3);
    chk("t1_wdin", 32'(RF_DIN), 32'h05A);
    tick();
    chk("t1_wen_e2", 32'(RF_WEN), 0);
    send(1'b0, 3'd3, 9'h000);
    tick();
    chk("t1_oen_r1", 32'(RF_OEN), 1);
    chk("t1_raddr", 32'(RF_ADDR), 3);
    chk("t1_valid_r1", 32'(RSP_VALID), 0);
    tick();
    chk("t1_oen_r2", 32'(RF_OEN), 0);
    chk("t1_valid_r2", 32'(RSP_VALID), 0);
    tick();
    chk("t1_valid_r3", 32'(RSP_VALID), 1);
    chk("t1_rsp_addr", 32'(RSP_ADDR), 3);
    chk("t1_rsp_data", 32'(RSP_DATA), 32'h05A);
    RSP_READY = 1'b1;
    tick();
    chk("t1_valid_clear", 32'(RSP_VALID), 0);

    // 2: burst of 5 writes, in order, at full write rate
    wbase = wlog.size();
    send(1'b1, 3'd1, 9'h101);
    send(1'b1, 3'd4, 9'h0A5);
    send(1'b1, 3'd6, 9'h1FF);
    send(1'b1, 3'd0, 9'h033);
    send(1'b1, 3'd7, 9'h14C);
    wait_idle("t2_idle");
    chk("t2_wcount", 32'(wlog.size() - wbase), 5);
    if (wlog.size() - wbase == 5) begin
      chk("t2_w0", {20'd0, wlog[wbase+0].a, wlog[wbase+0].d}, {20'd0, 3'd1, 9'h101});
      chk("t2_w1", {20'd0, wlog[wbase+1].a, wlog[wbase+1].d}, {20'd0, 3'd4, 9'h0A5});
      chk("t2_w2", {20'd0, wlog[wbase+2].a, wlog[wbase+2].d}, {20'd0, 3'd6, 9'h1FF});
      chk("t2_w3", {20'd0, wlog[wbase+3].a, wlog[wbase+3].d}, {20'd0, 3'd0, 9'h033});
      chk("t2_w4", {20'd0, wlog[wbase+4].a, wlog[wbase+4].d}, {20'd0, 3'd7, 9'h14C});
      for (int i = 1; i < 5; i++)
        chk("t2_gap", 32'(wlog[wbase+i].t - wlog[wbase+i-1].t), 32'(WR_GAP));
    end

    // 3: stalled response, FIFO fills behind it
    RSP_READY = 1'b0;
    send(1'b0, 3'd3, 9'h000);
    repeat (3) tick();
    chk("t3_valid", 32'(RSP_VALID), 1);
    chk("t3_data", 32'(RSP_DATA), 32'h05A);
    send(1'b1, 3'd5, 9'h0C3);
    chk("t3_hold_data", 32'(RSP_DATA), 32'h05A);
    send(1'b1, 3'd2, 9'h111);
    chk("t3_hold_data", 32'(RSP_DATA), 32'h05A);
    send(1'b0, 3'd5, 9'h000);
    chk("t3_hold_data", 32'(RSP_DATA), 32'h05A);
    send(1'b1, 3'd6, 9'h077);
    chk("t3_hold_valid", 32'(RSP_VALID), 1);
    chk("t3_full_ready", 32'(CMD_READY), 0);
    repeat (2) begin
      tick();
      chk("t3_hold_valid", 32'(RSP_VALID), 1);
      chk("t3_hold_data", 32'(RSP_DATA), 32'h05A);
    end
    RSP_READY = 1'b1;
    tick();
    chk("t3_valid_clear", 32'(RSP_VALID), 0);
    chk("t3_full_at_pop", 32'(CMD_READY), 0);
    tick();
    chk("t3_resume_wen", 32'(RF_WEN), 1);
    chk("t3_resume_addr", 32'(RF_ADDR), 5);
    chk("t3_resume_din", 32'(RF_DIN), 32'h0C3);
    chk("t3_ready_back", 32'(CMD_READY), 1);
    wait_rsp("t3_rsp2_timeout");
    chk("t3_rsp2_addr", 32'(RSP_ADDR), 5);
    chk("t3_rsp2_data", 32'(RSP_DATA), 32'h0C3);
    wait_idle("t3_idle");

    // 4: reset during RD_WAIT with two commands queued
    send(1'b0, 3'd4, 9'h000);
    send(1'b1, 3'd1, 9'h0F0);
    send(1'b1, 3'd2, 9'h00F);
    RST = 1'b1;
    #1;
    chk("t4_wen", 32'(RF_WEN), 0);
    chk("t4_oen", 32'(RF_OEN), 0);
    chk("t4_rf_addr", 32'(RF_ADDR), 0);
    chk("t4_rf_din", 32'(RF_DIN), 0);
    chk("t4_rsp_valid", 32'(RSP_VALID), 0);
    chk("t4_rsp_addr", 32'(RSP_ADDR), 0);
    chk("t4_rsp_data", 32'(RSP_DATA), 0);
    chk("t4_busy", 32'(BUSY), 0);
    tick();
    tick();
    RST = 1'b0;
    rsp0  = rsp_cyc;
    wbase = wlog.size();
    repeat (8) tick();
    chk("t4_no_rsp", 32'(rsp_cyc - rsp0), 0);
    chk("t4_no_write", 32'(wlog.size() - wbase), 0);
    chk("t4_busy_after", 32'(BUSY), 0);

    // 5: write every address, read every address
    rlog.delete();
    for (int i = 0; i < 8; i++) send(1'b1, 3'(i), d5[i]);
    for (int i = 0; i < 8; i++) send(1'b0, 3'(i), 9'h000);
    wait_idle("t5_idle");
    chk("t5_rcount", 32'(rlog.size()), 8);
    if (rlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("t5_rsp", 32'(rlog[i]), {20'd0, 3'(i), d5[i]});
    chk("t5_wen_oen_overlap", 32'(both_cnt), 0);

`ifdef REG_FILE_CTRL_VERIFY_EN
    // 6: corrupted readback of addr 2 flags VERIFY_ERR
    corrupt_a2 = 1'b1;
    rsp0 = rsp_cyc;
    send(1'b1, 3'd1, 9'h0AA);
    wait_idle("t6_idle1");
    chk("t6_err_clean", 32'(VERIFY_ERR), 0);
    wbase = wlog.size();
    send(1'b1, 3'd2, 9'h0BB);
    send(1'b1, 3'd3, 9'h0CC);
    wait_idle("t6_idle2");
    chk("t6_err_set", 32'(VERIFY_ERR), 1);
    chk("t6_wcount", 32'(wlog.size() - wbase), 2);
    if (wlog.size() - wbase == 2)
      chk("t6_gap", 32'(wlog[wbase+1].t - wlog[wbase].t), 32'd40);
    repeat (5) tick();
    chk("t6_err_sticky", 32'(VERIFY_ERR), 1);
    chk("t6_no_rsp", 32'(rsp_cyc - rsp0), 0);
    chk("t6_overlap", 32'(both_cnt), 0);
    corrupt_a2 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
